// File: rtl/apb_gpio_master.sv
// APB requester: turns one command/response-port transaction into a SETUP+ACCESS APB transfer.
// Optional ACCESS-phase timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_gpio_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic              PREADY
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_done;
  logic                w_timeout;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [DATA_W-1:0]   r_rsp_rdata;

  // Bus controls decode straight from the state register so an async reset clears them at once.
  assign cmd_ready = (r_state == S_IDLE);
  assign PSEL      = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE   = (r_state == S_ACCESS);
  assign rsp_valid = (r_state == S_RESP);
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_rdata = r_rsp_rdata;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_done    = (r_state == S_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_tcnt;
  logic             r_rsp_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tcnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_tcnt <= '0;
    end else if ((r_state == S_ACCESS) && !PREADY) begin
      r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

  // A PREADY arriving on the final count edge still completes normally.
  assign w_timeout = (r_state == S_ACCESS) && !PREADY &&
                     (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_err <= 1'b0;
    end else if (w_done) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (PREADY || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Address/data/direction load only on accept and then hold, including while idle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_rdata <= '0;
    end else if (w_done) begin
      r_rsp_rdata <= r_pwrite ? '0 : PRDATA1;
    end else if (w_timeout) begin
      r_rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_apb_gpio_master.sv
// Bench for apb_gpio_master: directed and random commands against a transaction-level model,
// acting as the APB slave with programmable wait states.
module tb_apb_gpio_master;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA1;
  logic              PREADY;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  apb_gpio_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered mid-cycle in IDLE; returns at the negedge of the first IDLE cycle after RESP.
  task automatic do_cmd(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input int waits, input logic [DATA_W-1:0] prd);
    logic [DATA_W-1:0] exp_r;
    int t0;
    exp_r = wr ? '0 : prd;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    PREADY = 1'b0; PRDATA1 = DATA_W'($urandom);
    #1;
    chk("idle_ready", cmd_ready, 1);
    @(posedge PCLK);
    #1;
    t0 = cyc;
    cmd_valid = 1'b0; cmd_write = ~wr;
    cmd_addr = ADDR_W'($urandom); cmd_wdata = DATA_W'($urandom);
    @(negedge PCLK);
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_ready", cmd_ready, 0);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwdata", PWDATA, d);
    chk("setup_pwrite", PWRITE, wr);
    for (int k = 0; k <= waits; k++) begin
      @(posedge PCLK);
      #1;
      PREADY  = (k == waits);
      PRDATA1 = (k == waits) ? prd : DATA_W'($urandom);
      @(negedge PCLK);
      chk("access_psel", PSEL, 1);
      chk("access_penable", PENABLE, 1);
      chk("access_paddr", PADDR, a);
      chk("access_pwdata", PWDATA, d);
      chk("access_pwrite", PWRITE, wr);
      chk("access_rsp_valid", rsp_valid, 0);
      chk("access_err", rsp_err, 0);
    end
    @(posedge PCLK);
    #1;
    PREADY = 1'b0; PRDATA1 = DATA_W'($urandom);
    @(negedge PCLK);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_psel", PSEL, 0);
    chk("resp_penable", PENABLE, 0);
    chk("resp_rdata", rsp_rdata, exp_r);
    chk("resp_err", rsp_err, 0);
    chk("resp_ready", cmd_ready, 0);
    chk("resp_latency", cyc - t0, 2 + waits);
    @(negedge PCLK);
    chk("post_valid", rsp_valid, 0);
    chk("post_ready", cmd_ready, 1);
    chk("post_rdata_held", rsp_rdata, exp_r);
    chk("post_paddr_held", PADDR, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int got_rsp;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; PRDATA1 = '0; PREADY = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    PRESETn = 1'b1;
    #1;
    chk("rst_ready", cmd_ready, 1);

    do_cmd(1'b1, 8'h01, 8'hFF, 0, 8'h3C);
    do_cmd(1'b0, 8'h00, 8'h12, 0, 8'hA5);
    do_cmd(1'b0, 8'h01, 8'h00, 3, 8'h5A);
    do_cmd(1'b1, 8'h00, 8'h81, 3, 8'hEE);

    // Back-to-back: cmd_valid held high, slave always ready -> 4-cycle cadence.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h0F; PREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge PCLK);
      chk("b2b_ready", cmd_ready, (i % 4) == 0);
      chk("b2b_psel", PSEL, ((i % 4) == 1) || ((i % 4) == 2));
      chk("b2b_rsp_valid", rsp_valid, (i % 4) == 3);
    end
    cmd_valid = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    chk("b2b_idle_ready", cmd_ready, 1);

    // Reset while in ACCESS with PREADY low, then released with PREADY high.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00;
    @(posedge PCLK); #1 cmd_valid = 1'b0;
    @(posedge PCLK); #2;
    chk("pre_rst_penable", PENABLE, 1);
    PREADY = 1'b1;
    PRESETn = 1'b0;
    #1;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_paddr", PADDR, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    got_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (rsp_valid) got_rsp++;
    end
    chk("postrst_no_rsp", got_rsp, 0);
    chk("postrst_ready", cmd_ready, 1);
    PREADY = 1'b0;
    do_cmd(1'b0, 8'h00, 8'h00, 1, 8'hC3);

`ifdef APB_MASTER_TIMEOUT_EN
    do_cmd(1'b0, 8'h01, 8'h00, TIMEOUT_CYCLES - 1, 8'h77);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00; PREADY = 1'b0; PRDATA1 = 8'hFF;
    @(posedge PCLK); #1 cmd_valid = 1'b0;
    n_acc = 0;
    got_rsp = 0;
    for (int i = 0; i < 40 && got_rsp == 0; i++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        got_rsp = 1;
        chk("to_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_psel", PSEL, 0);
      end else if (PENABLE) begin
        n_acc++;
      end
    end
    chk("to_seen", got_rsp, 1);
    chk("to_access_cycles", n_acc, TIMEOUT_CYCLES);
    @(negedge PCLK);
    do_cmd(1'b1, 8'h01, 8'h44, 0, 8'h00);
`else
    do_cmd(1'b0, 8'h01, 8'h00, 20, 8'h96);
    n_acc = 0;
`endif

    for (int i = 0; i < 16; i++) begin
      do_cmd(1'($urandom), ADDR_W'($urandom_range(0, 1)), DATA_W'($urandom),
             int'($urandom_range(0, 4)), DATA_W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
